// File: rtl/rggen_host_arbiter.sv
// Round-robin arbiter sharing one register-block bus port between HOSTS requesters.
// One access is outstanding downstream at a time; an optional timeout forces an error completion.
module rggen_host_arbiter #(
  parameter int HOSTS         = 2,
  parameter int ADDRESS_WIDTH = 8,
  parameter int BUS_WIDTH     = 32,
  parameter int TIMEOUT       = 0
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [HOSTS-1:0]                i_host_valid,
  input  logic [2*HOSTS-1:0]              i_host_access,
  input  logic [ADDRESS_WIDTH*HOSTS-1:0]  i_host_address,
  input  logic [BUS_WIDTH*HOSTS-1:0]      i_host_write_data,
  input  logic [BUS_WIDTH/8*HOSTS-1:0]    i_host_strobe,
  output logic [HOSTS-1:0]                o_host_ready,
  output logic [1:0]                      o_host_status,
  output logic [BUS_WIDTH-1:0]            o_host_read_data,
  output logic                            o_valid,
  output logic [1:0]                      o_access,
  output logic [ADDRESS_WIDTH-1:0]        o_address,
  output logic [BUS_WIDTH-1:0]            o_write_data,
  output logic [BUS_WIDTH/8-1:0]          o_strobe,
  input  logic                            i_ready,
  input  logic [1:0]                      i_status,
  input  logic [BUS_WIDTH-1:0]            i_read_data
);
  localparam int BW = BUS_WIDTH / 8;
  localparam int GW = (HOSTS > 1) ? $clog2(HOSTS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e                   state_q, state_d;
  logic [GW-1:0]            grant_q, last_q, sel;
  logic                     found;
  int                       idx;
  logic [CW-1:0]            count_q;
  logic                     timeout;
  logic [1:0]               access_q;
  logic [ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]     wdata_q;
  logic [BW-1:0]            strobe_q;
  logic [1:0]               status_q;
  logic [BUS_WIDTH-1:0]     rdata_q;
  logic [HOSTS-1:0]         host_ready_q;

  // Search starts just after the last granted host so every requester is served in turn.
  always_comb begin
    sel   = last_q;
    found = 1'b0;
    idx   = 0;
    for (int i = 1; i <= HOSTS; i++) begin
      idx = (int'(last_q) + i) % HOSTS;
      if (!found && i_host_valid[idx]) begin
        found = 1'b1;
        sel   = GW'(idx);
      end
    end
  end

  assign timeout = (TIMEOUT > 0) && (count_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = BUSY;
      BUSY:    if (i_ready || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_q       <= GW'(HOSTS - 1);
      count_q      <= '0;
      access_q     <= '0;
      address_q    <= '0;
      wdata_q      <= '0;
      strobe_q     <= '0;
      status_q     <= '0;
      rdata_q      <= '0;
      host_ready_q <= '0;
    end else begin
      state_q      <= state_d;
      host_ready_q <= '0;
      case (state_q)
        IDLE: if (found) begin
          grant_q   <= sel;
          last_q    <= sel;
          count_q   <= '0;
          access_q  <= i_host_access[int'(sel)*2 +: 2];
          address_q <= i_host_address[int'(sel)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
          wdata_q   <= i_host_write_data[int'(sel)*BUS_WIDTH +: BUS_WIDTH];
          strobe_q  <= i_host_strobe[int'(sel)*BW +: BW];
        end
        BUSY: begin
          // A same-cycle i_ready beats the timeout.
          if (i_ready) begin
            status_q     <= i_status;
            rdata_q      <= i_read_data;
            host_ready_q <= HOSTS'(1) << grant_q;
          end else if (timeout) begin
            status_q     <= 2'd2;
            rdata_q      <= '0;
            host_ready_q <= HOSTS'(1) << grant_q;
          end else if (count_q != CNT_MAX) begin
            count_q <= count_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_valid          = (state_q == BUSY);
  assign o_access         = access_q;
  assign o_address        = address_q;
  assign o_write_data     = wdata_q;
  assign o_strobe         = strobe_q;
  assign o_host_ready     = host_ready_q;
  assign o_host_status    = status_q;
  assign o_host_read_data = rdata_q;
endmodule

// File: tb/tb_rggen_host_arbiter.sv
// Bench for rggen_host_arbiter: directed scenarios plus randomized traffic against a
// round-robin reference model (3 hosts, timeout of 4 BUSY cycles).
module tb_rggen_host_arbiter;
  localparam int H = 3, AW = 8, DW = 32, BW = 4, TO = 4;

  typedef struct packed {
    logic [1:0]    acc;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] strb;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [H-1:0]   h_valid;
  logic [1:0]     h_acc [H];
  logic [AW-1:0]  h_addr[H];
  logic [DW-1:0]  h_data[H];
  logic [BW-1:0]  h_strb[H];
  logic [2*H-1:0]  host_access;
  logic [AW*H-1:0] host_address;
  logic [DW*H-1:0] host_wdata;
  logic [BW*H-1:0] host_strobe;
  logic [H-1:0]   o_host_ready;
  logic [1:0]     o_host_status;
  logic [DW-1:0]  o_host_read_data;
  logic           o_valid;
  logic [1:0]     o_access;
  logic [AW-1:0]  o_address;
  logic [DW-1:0]  o_write_data;
  logic [BW-1:0]  o_strobe;
  logic           ds_ready;
  logic [1:0]     ds_status;
  logic [DW-1:0]  ds_rdata;

  for (genvar gi = 0; gi < H; gi++) begin : g_pack
    assign host_access [2*gi  +: 2]  = h_acc[gi];
    assign host_address[AW*gi +: AW] = h_addr[gi];
    assign host_wdata  [DW*gi +: DW] = h_data[gi];
    assign host_strobe [BW*gi +: BW] = h_strb[gi];
  end

  rggen_host_arbiter #(.HOSTS(H), .ADDRESS_WIDTH(AW), .BUS_WIDTH(DW), .TIMEOUT(TO)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_host_valid(h_valid), .i_host_access(host_access), .i_host_address(host_address),
    .i_host_write_data(host_wdata), .i_host_strobe(host_strobe),
    .o_host_ready(o_host_ready), .o_host_status(o_host_status), .o_host_read_data(o_host_read_data),
    .o_valid(o_valid), .o_access(o_access), .o_address(o_address),
    .o_write_data(o_write_data), .o_strobe(o_strobe),
    .i_ready(ds_ready), .i_status(ds_status), .i_read_data(ds_rdata)
  );

  int errors = 0, checks = 0;
  int m_last;

  // observations returned by serve
  bit          seen, stable, az;
  int          vcyc;
  logic [H-1:0] hr;
  logic [1:0]  hs;
  logic [DW-1:0] hd;
  cmd_t        cmd;
  time         tp;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic do_reset;
    rst = 1'b1; h_valid = '0; ds_ready = 1'b0; ds_status = '0; ds_rdata = '0;
    for (int h = 0; h < H; h++) begin
      h_acc[h] = '0; h_addr[h] = '0; h_data[h] = '0; h_strb[h] = '0;
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    m_last = H - 1;
  endtask

  task automatic new_req(input int h);
    h_valid[h] = 1'b1;
    h_acc[h]   = 2'($urandom);
    h_addr[h]  = 8'($urandom);
    h_data[h]  = $urandom;
    h_strb[h]  = 4'($urandom);
  endtask

  // Acts as the downstream slave for one access; lat = BUSY cycle carrying i_ready (0 = never).
  // Returns at the IDLE-cycle negedge that follows the completion pulse.
  task automatic serve(input int lat, input logic [1:0] st, input logic [DW-1:0] rd, input int mut);
    seen = 0; vcyc = 0; hr = '0; hs = '0; hd = '0; cmd = '0; stable = 1; az = 1; tp = 0;
    for (int i = 0; i < 20 && o_valid !== 1'b1; i++) @(negedge clk);
    if (o_valid !== 1'b1) return;
    seen = 1;
    cmd = cmd_t'({o_access, o_address, o_write_data, o_strobe});
    while (o_valid === 1'b1 && vcyc < 20) begin
      vcyc++;
      if (cmd_t'({o_access, o_address, o_write_data, o_strobe}) !== cmd) stable = 0;
      if (mut >= 0 && vcyc == 1) begin h_addr[mut] = 8'h0C; h_data[mut] = 32'h5678; end
      ds_ready = (vcyc == lat); ds_status = st; ds_rdata = rd;
      @(negedge clk);
    end
    ds_ready = 1'b0; ds_status = 2'($urandom); ds_rdata = $urandom;
    hr = o_host_ready; hs = o_host_status; hd = o_host_read_data; tp = $time;
    @(negedge clk);
    az = (o_host_ready === '0) && (o_valid === 1'b0);
  endtask

  task automatic test_reset;
    rst = 1'b1; h_valid = '1; ds_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", o_valid); end
    checks++; if (o_host_ready !== '0) begin errors++; $display("FAIL reset_host_ready got=%b want=0", o_host_ready); end
    checks++; if (o_host_status !== '0) begin errors++; $display("FAIL reset_status got=%0d want=0", o_host_status); end
    checks++; if (o_host_read_data !== '0) begin errors++; $display("FAIL reset_rdata got=%h want=0", o_host_read_data); end
    checks++; if ({o_access, o_address, o_write_data, o_strobe} !== '0) begin
      errors++; $display("FAIL reset_cmd got=%h want=0", {o_access, o_address, o_write_data, o_strobe});
    end
    h_valid = '0;
  endtask

  task automatic test_single_read;
    time t0;
    do_reset;
    h_valid[1] = 1'b1; h_acc[1] = 2'b00; h_addr[1] = 8'h10; h_strb[1] = 4'h0;
    serve(2, 2'd0, 32'hCAFE_F00D, -1);
    t0 = tp;
    checks++; if (!seen || vcyc != 2) begin errors++; $display("FAIL read_valid_cycles got=%0d want=2", vcyc); end
    checks++; if (hr !== 3'b010) begin errors++; $display("FAIL read_host_ready got=%b want=010", hr); end
    checks++; if (hd !== 32'hCAFE_F00D || hs !== 2'd0) begin
      errors++; $display("FAIL read_resp got=%h/%0d want=cafef00d/0", hd, hs);
    end
    checks++; if (cmd.addr !== 8'h10 || cmd.acc !== 2'b00) begin
      errors++; $display("FAIL read_cmd got=%h/%b want=10/00", cmd.addr, cmd.acc);
    end
    checks++; if (!az) begin errors++; $display("FAIL read_pulse_width got=%b want=000", o_host_ready); end
    h_valid[1] = 1'b0;
  endtask

  task automatic test_fairness;
    time tprev;
    do_reset;
    h_valid = '1;
    tprev = 0;
    for (int k = 0; k < 6; k++) begin
      serve(1, 2'd0, 32'(k), -1);
      checks++; if (hr !== (3'(1) << (k % 3))) begin
        errors++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, hr, 3'(1) << (k % 3));
      end
      if (k > 0) begin
        checks++; if (tp - tprev != 30) begin
          errors++; $display("FAIL rr_spacing[%0d] got=%0t want=30", k, tp - tprev);
        end
      end
      tprev = tp;
    end
    h_valid = '0;
  endtask

  task automatic test_timeout;
    do_reset;
    new_req(2);
    serve(0, 2'd1, 32'hDEAD_BEEF, -1);
    checks++; if (!seen || vcyc != TO) begin errors++; $display("FAIL to_valid_cycles got=%0d want=%0d", vcyc, TO); end
    checks++; if (hr !== 3'b100 || hs !== 2'd2 || hd !== '0) begin
      errors++; $display("FAIL to_resp got=%b/%0d/%h want=100/2/0", hr, hs, hd);
    end
    serve(TO, 2'd1, 32'hA5A5_0001, -1);
    checks++; if (vcyc != TO || hr !== 3'b100 || hs !== 2'd1 || hd !== 32'hA5A5_0001) begin
      errors++; $display("FAIL to_ready_wins got=%0d/%b/%0d/%h want=4/100/1/a5a50001", vcyc, hr, hs, hd);
    end
    h_valid = '0;
  endtask

  task automatic test_latched_payload;
    do_reset;
    h_valid[0] = 1'b1; h_acc[0] = 2'b01; h_addr[0] = 8'h08; h_data[0] = 32'h1234; h_strb[0] = 4'hF;
    serve(3, 2'd0, 32'h0, 0);
    checks++; if (cmd !== cmd_t'({2'b01, 8'h08, 32'h1234, 4'hF}) || !stable) begin
      errors++; $display("FAIL latched_cmd got=%h stable=%0d want=%h", cmd, stable, cmd_t'({2'b01, 8'h08, 32'h1234, 4'hF}));
    end
    checks++; if (hr !== 3'b001 || vcyc != 3) begin errors++; $display("FAIL latched_done got=%b/%0d want=001/3", hr, vcyc); end
    h_valid = '0;
  endtask

  task automatic test_reset_mid;
    int bad;
    do_reset;
    new_req(0);
    serve(1, 2'd0, 32'h1, -1);
    new_req(0);
    for (int i = 0; i < 10 && o_valid !== 1'b1; i++) @(negedge clk);
    checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b want=1", o_valid); end
    rst = 1'b1; h_valid = '0;
    @(negedge clk);
    checks++; if ({o_valid, o_host_ready, o_host_status, o_host_read_data, o_access, o_address, o_write_data, o_strobe} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs got=%b/%b/%h want=all zero", o_valid, o_host_ready,
                         {o_access, o_address, o_write_data, o_strobe});
    end
    rst = 1'b0; m_last = H - 1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (o_host_ready !== '0 || o_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL mid_no_pulse got=%0d want=0", bad); end
    new_req(0); new_req(1);
    serve(1, 2'd0, 32'h2, -1);
    checks++; if (hr !== 3'b001) begin errors++; $display("FAIL mid_regrant got=%b want=001", hr); end
    h_valid = '0;
  endtask

  task automatic test_random;
    int g, lat, exp_vc;
    logic [1:0] st, exp_hs;
    logic [DW-1:0] rd, exp_hd;
    cmd_t exp_cmd;
    do_reset;
    for (int h = 0; h < H; h++) if ($urandom_range(0, 1) == 1) new_req(h);
    if (h_valid == '0) new_req(int'($urandom_range(0, H - 1)));
    for (int n = 0; n < 40; n++) begin
      g = -1;
      for (int i = 1; i <= H; i++) if (g < 0 && h_valid[(m_last + i) % H]) g = (m_last + i) % H;
      exp_cmd = cmd_t'({h_acc[g], h_addr[g], h_data[g], h_strb[g]});
      lat = int'($urandom_range(1, 6)); st = 2'($urandom); rd = $urandom;
      exp_vc = (lat <= TO) ? lat : TO;
      exp_hs = (lat <= TO) ? st : 2'd2;
      exp_hd = (lat <= TO) ? rd : '0;
      serve(lat, st, rd, -1);
      checks++; if (!seen || hr !== (3'(1) << g)) begin
        errors++; $display("FAIL rand_grant[%0d] got=%b want=%b", n, hr, 3'(1) << g);
      end
      checks++; if (cmd !== exp_cmd || !stable) begin
        errors++; $display("FAIL rand_cmd[%0d] got=%h want=%h", n, cmd, exp_cmd);
      end
      checks++; if (vcyc != exp_vc || hs !== exp_hs || hd !== exp_hd || !az) begin
        errors++; $display("FAIL rand_resp[%0d] got=%0d/%0d/%h want=%0d/%0d/%h", n, vcyc, hs, hd, exp_vc, exp_hs, exp_hd);
      end
      m_last = g; h_valid[g] = 1'b0;
      for (int h = 0; h < H; h++) if (!h_valid[h] && $urandom_range(0, 1) == 1) new_req(h);
      if (h_valid == '0) new_req(int'($urandom_range(0, H - 1)));
    end
    h_valid = '0;
  endtask

  initial begin
    rst = 1'b1; h_valid = '0; ds_ready = 1'b0; ds_status = '0; ds_rdata = '0;
    for (int h = 0; h < H; h++) begin
      h_acc[h] = '0; h_addr[h] = '0; h_data[h] = '0; h_strb[h] = '0;
    end
    m_last = H - 1;
    test_reset;
    test_single_read;
    test_fairness;
    test_timeout;
    test_latched_payload;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
